// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Summary  : Show-ahead transmit FIFO between the host and the UART TX FSM.
//            Requests a frame while data is queued; the FSM load pulse pops.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_flags,
    input  logic                  load,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_DEPTH_INT = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH   = (ADDR_WIDTH + 1)'(c_DEPTH_INT);
    localparam logic [ADDR_WIDTH:0] c_AFULL   = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_ZERO    = '0;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH_INT];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;
    logic w_wr_drop;
    logic w_rd_empty;

    // Flags decode from the registered level only, so no input reaches an output.
    assign w_empty = (r_level == c_ZERO);
    assign w_full  = (r_level == c_DEPTH);

    assign w_do_rd    = load & ~w_empty;
    assign w_do_wr    = wr_en & (~w_full | w_do_rd);
    assign w_wr_drop  = wr_en & w_full & ~w_do_rd;
    assign w_rd_empty = load & w_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_rd && !w_do_wr) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // A new error event takes priority over a coincident clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_level >= c_AFULL);
    assign tx_start    = ~w_empty;
    assign tx_data     = r_mem[r_rd_ptr];
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire
